wshb_stream_sink: RTL and testbench
===================================

WSHB_STREAM_SINK -- requirements
Module: wshb_stream_sink

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 32-bit words, power of two, >= 4.
REQ-002 sys_clk  in  1  system clock (100 MHz); all logic on rising edge.
REQ-003 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-004 wb_cyc  in  1  Wishbone cycle valid.
REQ-005 wb_stb  in  1  Wishbone strobe.
REQ-006 wb_we  in  1  1 = write (push pixel word), 0 = read (status).
REQ-007 wb_adr  in  32  address; ignored except for status reads.
REQ-008 wb_dat_ms  in  32  write data, master to slave.
REQ-009 wb_sel  in  4  byte selects.
REQ-010 wb_cti  in  3  cycle type; accepted, ignored (classic handling only).
REQ-011 wb_bte  in  2  burst type; accepted, ignored.
REQ-012 wb_ack  out  1  normal termination.
REQ-013 wb_err  out  1  error termination.
REQ-014 wb_rty  out  1  retry; tied 0.
REQ-015 wb_dat_sm  out  32  read data, slave to master.
REQ-016 out_valid  out  1  downstream word available.
REQ-017 out_data  out  32  downstream word.
REQ-018 out_ready  in  1  downstream accepts word when out_valid & out_ready.
REQ-019 level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-020 Request = wb_cyc & wb_stb & ~wb_ack & ~wb_err; evaluated each cycle.
REQ-021 Write request with wb_sel == 4'hF and level < DEPTH: push wb_dat_ms, assert wb_ack next cycle for exactly one cycle.
REQ-022 Write request with wb_sel != 4'hF: no push, assert wb_err next cycle for one cycle.
REQ-023 Write request with level == DEPTH (full): no push, no termination; stall until not full (backpressure by withheld ack).
REQ-024 Full decision uses registered level at request cycle; a pop in the same cycle does not allow acceptance until the following cycle.
REQ-025 Read request: wb_dat_sm = {zero pad, level in bits [15:0]...} defined as bit0 empty, bit1 full, bits[15:8] level (zero-extended), others 0; wb_ack next cycle, one cycle.
REQ-026 Max throughput: one write per 2 cycles (request, ack).
REQ-027 wb_dat_sm = 0 whenever not acking a read.
REQ-028 Request dropped (wb_cyc or wb_stb low) before termination: no side effect.
REQ-029 Push latency: word pushed into empty FIFO appears on out_data with out_valid high on the cycle after wb_ack.
REQ-030 out_data is show-ahead: holds head word while out_valid & ~out_ready.
REQ-031 Pop on out_valid & out_ready; simultaneous push and pop leaves level unchanged.
REQ-032 Pointers wrap modulo DEPTH; level range 0..DEPTH, never exceeds.
REQ-033 Word order preserved exactly (FIFO).

Reset
REQ-034 sys_rst_n low at rising edge: level 0, pointers 0, out_valid 0, wb_ack 0, wb_err 0, wb_dat_sm 0.
REQ-035 Reset mid-transfer discards FIFO contents and any pending termination; stored data RAM not cleared.
REQ-036 First request accepted no earlier than the first cycle with sys_rst_n high.

Structure
REQ-037 Package wshb_sink_pkg: status bit positions, status word layout, default DEPTH.
REQ-038 One sub-module: sync_fifo (single clock, show-ahead, DEPTH parameter, full/empty/level).
REQ-039 Storage inferable as RAM; no combinational path from wb_stb to wb_ack.

Verification
REQ-040 Reset then 3 writes 0x11111111, 0x22222222, 0x33333333 (sel F), out_ready=1 -> each ack 1 cycle after stb, same values on out_data in order, level returns 0.
REQ-041 out_ready=0, 17 writes with DEPTH=16 -> 16 acks, 17th stalled; status read shows full=1 level=16; raise out_ready one cycle -> 17th acked next-but-one cycle.
REQ-042 Write with sel=4'h3 -> wb_err 1 cycle, wb_ack 0, level unchanged.
REQ-043 Status read on empty FIFO -> wb_dat_sm = 0x00000001, ack 1 cycle.
REQ-044 Continuous push/pop with out_ready=1 for 100 words incrementing -> data matches, level never > 1.
REQ-045 Assert sys_rst_n=0 with level=5 and request pending -> next cycle level 0, out_valid 0, no ack.

Source files
------------

// File: rtl/wshb_sink_pkg.sv
// Shared constants for the Wishbone stream sink: status word layout,
// termination kinds and the default FIFO depth.
package wshb_sink_pkg;

  // Default FIFO depth in 32-bit words (power of two, at least 4)
  localparam int DEFAULT_DEPTH = 16;

  // Status word layout returned on a read access
  localparam int STATUS_W       = 32;
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_W   = 8;

  // Only full-word writes carry a pixel word
  localparam logic [3:0] SEL_FULL_WORD = 4'hF;

  // How the current bus request will be terminated
  typedef enum logic [1:0] {
    TERM_NONE   = 2'd0,
    TERM_WR_ACK = 2'd1,
    TERM_RD_ACK = 2'd2,
    TERM_ERR    = 2'd3
  } term_e;

  // Assemble the status word; unused bits read as zero
  function automatic logic [STATUS_W-1:0] pack_status(
    input logic                    empty,
    input logic                    full,
    input logic [STAT_LEVEL_W-1:0] lvl
  );
    logic [STATUS_W-1:0] w;
    w                                  = '0;
    w[STAT_EMPTY_BIT]                  = empty;
    w[STAT_FULL_BIT]                   = full;
    w[STAT_LEVEL_LSB +: STAT_LEVEL_W]  = lvl;
    return w;
  endfunction

endpackage

// File: rtl/wshb_stream_sink_sync_fifo.sv
// Single-clock show-ahead FIFO. Storage is a plain array with a registered
// read port so it maps onto block RAM; the head word is prefetched into the
// read register one cycle after it has been written.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   ready_i,
  output logic                   out_valid_o,
  output logic [WIDTH-1:0]       out_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q, valid_d;

  logic push_ok;
  logic pop;

  assign full_o      = (level_q == DEPTH_L);
  assign empty_o     = (level_q == '0);
  assign level_o     = level_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = rdata_q;

  // A push into a full FIFO is refused here as a second line of defence
  assign push_ok = push_i & ~full_o;
  assign pop     = valid_q & ready_i;

  // Next-state for pointers, occupancy and head-valid flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // The word read this edge is valid only if it was already stored before
    // this edge; a word written now becomes visible one cycle later.
    valid_d = (level_q > LW'(pop));
  end

  // Storage write port (contents survive reset)
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Registered read of the next head word (show-ahead prefetch)
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[rd_ptr_d];
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/wshb_stream_sink.sv
// Wishbone classic slave that accepts full-word writes into a FIFO and
// streams them out with valid/ready. Reads return a status word. Every
// termination is registered, so a request costs at least two cycles and
// there is no combinational path from strobe to ack.
module wshb_stream_sink
  import wshb_sink_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   wb_cyc,
  input  logic                   wb_stb,
  input  logic                   wb_we,
  input  logic [31:0]            wb_adr,
  input  logic [31:0]            wb_dat_ms,
  input  logic [3:0]             wb_sel,
  input  logic [2:0]             wb_cti,
  input  logic [1:0]             wb_bte,
  output logic                   wb_ack,
  output logic                   wb_err,
  output logic                   wb_rty,
  output logic [31:0]            wb_dat_sm,
  output logic                   out_valid,
  output logic [31:0]            out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   dat_sm_q, dat_sm_d;

  logic          req;
  term_e         term;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;

  // Address and burst qualifiers carry no meaning for this slave
  logic unused_inputs;
  assign unused_inputs = ^{wb_adr, wb_cti, wb_bte};

  assign wb_ack    = ack_q;
  assign wb_err    = err_q;
  assign wb_rty    = 1'b0;
  assign wb_dat_sm = dat_sm_q;
  assign level     = fifo_level;

  // Classify the request; a full FIFO simply withholds termination
  always_comb begin
    req  = sys_rst_n & wb_cyc & wb_stb & ~ack_q & ~err_q;
    term = TERM_NONE;
    if (req) begin
      if (wb_we) begin
        if (wb_sel != SEL_FULL_WORD) begin
          term = TERM_ERR;
        end else if (!fifo_full) begin
          term = TERM_WR_ACK;
        end
      end else begin
        term = TERM_RD_ACK;
      end
    end
  end

  // Termination and read-data for the next cycle
  always_comb begin
    push     = (term == TERM_WR_ACK);
    ack_d    = (term == TERM_WR_ACK) || (term == TERM_RD_ACK);
    err_d    = (term == TERM_ERR);
    dat_sm_d = '0;
    if (term == TERM_RD_ACK) begin
      dat_sm_d = pack_status(fifo_empty, fifo_full,
                             STAT_LEVEL_W'(fifo_level));
    end
  end

  // Registered bus outputs; reset drops any pending termination
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_sm_q <= '0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_sm_q <= dat_sm_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i       (sys_clk),
    .rst_n_i     (sys_rst_n),
    .push_i      (push),
    .push_data_i (wb_dat_ms),
    .ready_i     (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

endmodule

// File: tb/tb_wshb_stream_sink.sv
// Directed bench for wshb_stream_sink with a data scoreboard on the stream
// output.
module tb_wshb_stream_sink;

  localparam int DEPTH = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_adr = '0;
  logic [31:0] wb_dat_ms = '0;
  logic [3:0]  wb_sel = '0;
  logic [2:0]  wb_cti = '0;
  logic [1:0]  wb_bte = '0;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_rty;
  logic [31:0] wb_dat_sm;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [$clog2(DEPTH):0] level;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  logic track_max = 1'b0;
  int max_level = 0;

  always #5 sys_clk = ~sys_clk;

  wshb_stream_sink #(.DEPTH(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_adr    (wb_adr),
    .wb_dat_ms (wb_dat_ms),
    .wb_sel    (wb_sel),
    .wb_cti    (wb_cti),
    .wb_bte    (wb_bte),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .wb_rty    (wb_rty),
    .wb_dat_sm (wb_dat_sm),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every word leaving the stream port must be the oldest pushed
  always @(negedge sys_clk) begin : mon
    logic [31:0] exp_w;
    if (sys_rst_n && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_w = sb_q.pop_front();
        chk("out_data", out_data, exp_w);
      end
    end
    if (track_max && int'(level) > max_level) max_level = int'(level);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic drive_bus(input logic we, input logic [31:0] d, input logic [3:0] sel);
    wb_cyc    = 1'b1;
    wb_stb    = 1'b1;
    wb_we     = we;
    wb_adr    = we ? 32'h0 : 32'h4;
    wb_dat_ms = d;
    wb_sel    = sel;
    wb_cti    = 3'b000;
    wb_bte    = 2'b00;
  endtask

  task automatic wb_idle();
    @(posedge sys_clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = '0; wb_dat_ms = '0;
    @(negedge sys_clk);
    chk("idle_ack", wb_ack, 0);
    chk("idle_err", wb_err, 0);
    chk("idle_dat_sm", wb_dat_sm, 0);
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] d, input logic [3:0] sel,
                         output logic a, output logic e, output logic [31:0] r, output int lat);
    bit done;
    done = 1'b0;
    a = 1'b0; e = 1'b0; r = '0; lat = 0;
    @(posedge sys_clk); #1;
    drive_bus(we, d, sel);
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge sys_clk);
      lat++;
      if (wb_ack || wb_err) begin
        a = wb_ack; e = wb_err; r = wb_dat_sm; done = 1'b1;
      end
    end
    chk("xfer_terminated", 32'(done), 1);
    $display("wb %s dat_ms=%08h sel=%h ack=%0b err=%0b dat_sm=%08h cycles=%0d level=%0d",
             we ? "WR" : "RD", d, sel, a, e, r, lat, level);
  endtask

  task automatic write_ok(input logic [31:0] d);
    logic a, e; logic [31:0] r; int lat;
    sb_q.push_back(d);
    wb_xfer(1'b1, d, 4'hF, a, e, r, lat);
    chk("wr_ack", a, 1);
    chk("wr_err", e, 0);
    chk("wr_lat", lat, 2);
  endtask

  task automatic read_status(input logic [31:0] expv, input string tag);
    logic a, e; logic [31:0] r; int lat;
    wb_xfer(1'b0, 32'h0, 4'hF, a, e, r, lat);
    chk({tag, "_ack"}, a, 1);
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_data"}, r, expv);
  endtask

  task automatic drain();
    @(posedge sys_clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge sys_clk);
    chk("drain_sb_empty", sb_q.size(), 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("drain_level", level, 0);
    chk("drain_valid", out_valid, 0);
  endtask

  initial begin
    logic a, e; logic [31:0] r; int lat;
    logic [31:0] d17;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ack", wb_ack, 0);
    chk("rst_err", wb_err, 0);
    chk("rst_rty", wb_rty, 0);
    chk("rst_dat_sm", wb_dat_sm, 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Three writes streamed out in order
    out_ready = 1'b1;
    write_ok(32'h11111111);
    chk("push_lat_not_yet", out_valid, 0);
    wb_idle();
    chk("push_lat_valid", out_valid, 1);
    chk("push_lat_data", out_data, 32'h11111111);
    write_ok(32'h22222222);
    write_ok(32'h33333333);
    wb_idle();
    drain();

    // Status read on empty FIFO
    read_status(32'h00000001, "rd_empty");
    wb_idle();

    // Partial byte select is refused with an error
    @(posedge sys_clk); #1;
    out_ready = 1'b0;
    write_ok(32'hAAAA0001);
    wb_idle();
    chk("err_level_before", level, 1);
    wb_xfer(1'b1, 32'hDEAD0003, 4'h3, a, e, r, lat);
    chk("err_err", e, 1);
    chk("err_ack", a, 0);
    chk("err_lat", lat, 2);
    wb_idle();
    chk("err_level_after", level, 1);
    read_status(32'h00000100, "rd_one");
    wb_idle();
    drain();

    // Fill to DEPTH, 17th write stalls until a pop frees a slot
    @(posedge sys_clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) write_ok(32'h41000000 + 32'(i));
    wb_idle();
    chk("full_level", level, DEPTH);
    d17 = 32'h41000000 + 32'(DEPTH);
    sb_q.push_back(d17);
    @(posedge sys_clk); #1;
    drive_bus(1'b1, d17, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      chk("stall_ack", wb_ack, 0);
      chk("stall_level", level, DEPTH);
    end
    wb_idle();
    read_status(32'h00001002, "rd_full");
    @(posedge sys_clk); #1;
    drive_bus(1'b1, d17, 4'hF);
    @(negedge sys_clk);
    chk("stall2_ack", wb_ack, 0);
    @(posedge sys_clk); #1;
    out_ready = 1'b1;
    @(negedge sys_clk);
    chk("pop_cycle_ack", wb_ack, 0);
    chk("pop_cycle_level", level, DEPTH);
    @(posedge sys_clk); #1;
    out_ready = 1'b0;
    @(negedge sys_clk);
    chk("accept_cycle_ack", wb_ack, 0);
    chk("accept_cycle_level", level, DEPTH - 1);
    @(negedge sys_clk);
    chk("late_ack", wb_ack, 1);
    chk("late_level", level, DEPTH);
    wb_idle();
    drain();

    // Continuous push/pop, 100 incrementing words
    max_level = 0;
    track_max = 1'b1;
    for (int i = 0; i < 100; i++) write_ok(32'h50000000 + 32'(i));
    wb_idle();
    drain();
    track_max = 1'b0;
    chk("max_level_le1", 32'(max_level <= 1), 1);

    // Reset with data stored and a request pending
    @(posedge sys_clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) write_ok(32'h60000000 + 32'(i));
    wb_idle();
    chk("pre_rst_level", level, 5);
    @(posedge sys_clk); #1;
    drive_bus(1'b1, 32'h66666666, 4'hF);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("rst_req_level", level, 5);
    @(negedge sys_clk);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ack", wb_ack, 0);
    sb_q.delete();
    @(negedge sys_clk);
    chk("mid_rst_ack2", wb_ack, 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("first_hi_ack", wb_ack, 0);
    chk("first_hi_level", level, 0);
    @(negedge sys_clk);
    chk("post_rst_ack", wb_ack, 1);
    chk("post_rst_level", level, 1);
    sb_q.push_back(32'h66666666);
    wb_idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
